// File: rtl/prototipo_uwu_pkg.sv
// Shared types, phase tables and widths for the prototipo_uwu stepper driver.
// Define HALF_STEP_EN to build the 8-entry half-step sequencer instead of wave drive.
package prototipo_uwu_pkg;

    // Coil drive vector, bit order {A,B,C,D}
    typedef logic [3:0] coil_t;

    localparam int unsigned PRESC_W = 24;

`ifdef HALF_STEP_EN
    localparam int unsigned PHASE_W = 3;
`else
    localparam int unsigned PHASE_W = 2;
`endif

    localparam int unsigned NUM_PHASES = 1 << PHASE_W;

    // Wave drive: one coil at a time
    localparam coil_t FULL_TABLE [4] = '{
        4'b1000, 4'b0100, 4'b0010, 4'b0001
    };

    // Half step: alternating single and adjacent-pair coils
    localparam coil_t HALF_TABLE [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    // Coil pattern for a given phase in the selected stepping mode
    function automatic coil_t phase_pattern(logic [PHASE_W-1:0] ph);
`ifdef HALF_STEP_EN
        return HALF_TABLE[ph];
`else
        return FULL_TABLE[ph];
`endif
    endfunction

endpackage

// File: rtl/prototipo_uwu_prescaler.sv
// Step-rate prescaler: counts enabled clocks, tick_c high on the CLK_DIV-th one.
module prototipo_uwu_prescaler
    import prototipo_uwu_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_c
);

    localparam logic [PRESC_W-1:0] TERMINAL = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    assign tick_c = en_i && !clr_i && (cnt_q == TERMINAL);

    // Next count: clear wins, wrap to zero on tick
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_c ? '0 : cnt_q + PRESC_W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prototipo_uwu_drv.sv
// Unipolar 4-coil stepper phase sequencer; coils driven while control is high.
// Build with HALF_STEP_EN defined for half-step (8-phase) operation.
module prototipo_uwu_drv
    import prototipo_uwu_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25000,
    parameter bit          REVERSE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic control,
    output logic A,
    output logic B,
    output logic C,
    output logic D
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;
    coil_t              coils_q;
    coil_t              coils_d;
    logic               tick_c;

    prototipo_uwu_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (control),
        .clr_i  (!control),
        .tick_c (tick_c)
    );

    // Show current phase while running; advance phase on prescaler tick, hold it when idle
    always_comb begin
        phase_d = phase_q;
        coils_d = '0;
        if (control) begin
            coils_d = phase_pattern(phase_q);
            if (tick_c) begin
                phase_d = REVERSE ? phase_q - PHASE_W'(1) : phase_q + PHASE_W'(1);
            end
        end
    end

    // Phase and coil output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
            coils_q <= '0;
        end else begin
            phase_q <= phase_d;
            coils_q <= coils_d;
        end
    end

    assign {A, B, C, D} = coils_q;

endmodule

// File: tb/tb_prototipo_uwu_drv.sv
// Directed bench for prototipo_uwu_drv: five instances with different CLK_DIV/REVERSE,
// expected coil patterns queued at stimulus time and compared after each edge.
module tb_prototipo_uwu_drv;

    localparam int NI = 5;
`ifdef HALF_STEP_EN
    localparam int NPH = 8;
`else
    localparam int NPH = 4;
`endif

    // inst0: reset tests, inst1: rotation, inst2: disable/resume, inst3: reverse, inst4: fwd div1
    localparam int unsigned DIVS [NI] = '{4, 2, 3, 1, 1};
    localparam bit          REVS [NI] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    typedef struct {
        int         inst;
        int         seq;
        logic [3:0] exp;
    } sb_t;

    logic               clk;
    logic [NI-1:0]      rstn;
    logic [NI-1:0]      ctl;
    logic [NI-1:0]      a_w, b_w, c_w, d_w;
    logic [NI-1:0][3:0] obs;

    sb_t sb_q [$];
    int  checks;
    int  errors;
    int  seq;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        prototipo_uwu_drv #(
            .CLK_DIV (DIVS[g]),
            .REVERSE (REVS[g])
        ) u_dut (
            .clk     (clk),
            .rst_n   (rstn[g]),
            .control (ctl[g]),
            .A       (a_w[g]),
            .B       (b_w[g]),
            .C       (c_w[g]),
            .D       (d_w[g])
        );
        assign obs[g] = {a_w[g], b_w[g], c_w[g], d_w[g]};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected pattern k steps from phase 0 (k may be negative)
    function automatic logic [3:0] tbl(int k);
        int         m;
        logic [3:0] t [8];
`ifdef HALF_STEP_EN
        t = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
        t = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
        m = k % NPH;
        if (m < 0) m += NPH;
        return t[m];
    endfunction

    task automatic push(input int inst, input logic [3:0] exp);
        sb_t e;
        e.inst = inst;
        e.seq  = seq;
        e.exp  = exp;
        seq++;
        sb_q.push_back(e);
    endtask

    // One clock edge, then drain the scoreboard and check coil-count bound on every instance
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            assert (obs[e.inst] === e.exp) else begin
                errors++;
                $error("FAIL sb inst%0d step%0d: got %b expected %b", e.inst, e.seq, obs[e.inst], e.exp);
            end
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            assert ($countones(obs[i]) <= 2) else begin
                errors++;
                $error("FAIL coil_count inst%0d: got %b expected at most two coils high", i, obs[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        seq    = 0;
        rstn   = '0;
        ctl    = '0;
        ctl[0] = 1'b1;

        // Reset held two edges, control high on inst0: everything off
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NI; i++) push(i, 4'b0000);
            tick();
        end
        #1 rstn = '1;

        // inst0 (DIV=4): first pattern held 4 clocks, then next
        for (int i = 0; i < 4; i++) begin
            push(0, tbl(0));
            tick();
        end
        push(0, tbl(1));
        tick();

        // Reset mid-run while showing second pattern, then resume from phase 0
        rstn[0] = 1'b0;
        push(0, 4'b0000);
        tick();
        rstn[0] = 1'b1;
        push(0, tbl(0));
        tick();
        ctl[0] = 1'b0;
        push(0, 4'b0000);
        tick();

        // inst1 (DIV=2): full rotation, each pattern held two clocks
        ctl[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(1, tbl(i / 2));
            tick();
        end
        ctl[1] = 1'b0;

        // inst2 (DIV=3): run to first edge of phase 2, drop control one cycle, resume
        ctl[2] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push(2, tbl(i / 3));
            tick();
        end
        ctl[2] = 1'b0;
        push(2, 4'b0000);
        tick();
        ctl[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(2, tbl(2));
            tick();
        end
        push(2, tbl(3));
        tick();
        ctl[2] = 1'b0;

        // inst3 (DIV=1, reverse): steps backwards every edge with wrap below phase 0
        ctl[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(3, tbl(-i));
            tick();
        end
        ctl[3] = 1'b0;

        // inst4 (DIV=1, forward): one step per edge through a full wrap
        ctl[4] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push(4, tbl(i));
            tick();
        end
        ctl[4] = 1'b0;
        push(4, 4'b0000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prototipo_uwu_drv.md
Name: prototipo_uwu_drv

Overview:
- Unipolar 4-coil stepper-motor phase sequencer for the dispenser/timer prototype.
- While `control` is high, it steps the coil pattern at a rate set by a clock prescaler.
- While `control` is low, all coils are de-energised.
- Sits below the countdown/timer controller, which raises `control` for the motor run window and drops it when the sensor trips or the run ends.

Parameters:
- CLK_DIV, default 25000: `clk` cycles per motor step; legal range 1..2^24-1.
- REVERSE, default 0: 0 steps A→B→C→D; 1 steps D→C→B→A.

Ports:
- clk  input  1  step-rate clock (driven from the faster system clock, `clk2` at the parent).
- rst_n  input  1  synchronous, active-low reset.
- control  input  1  run enable; 1 = step motor, 0 = coils off.
- A  output  1  coil A drive, active high.
- B  output  1  coil B drive, active high.
- C  output  1  coil C drive, active high.
- D  output  1  coil D drive, active high.

Behaviour:
- All state is updated only on posedge `clk`. Outputs A..D are registered.
- Reset: rst_n=0 at a clock edge gives {A,B,C,D}=0000, phase=0, prescaler=0. Reset has priority over `control`.
- Full-step (wave drive) table:
  - phase 0 = 1000
  - phase 1 = 0100
  - phase 2 = 0010
  - phase 3 = 0001
  - Written as {A,B,C,D}.
- control=0:
  - outputs are 0000 on the next edge;
  - prescaler cleared to 0;
  - phase held, so motion resumes from the same position.
- control=1:
  - outputs = table[phase] on every edge;
  - prescaler increments each edge.
  - When the prescaler equals CLK_DIV-1, it wraps to 0 and phase advances.
  - Advance is +1 mod 4 (REVERSE=0) or -1 mod 4 (REVERSE=1).
  - The new pattern appears one edge after the advance.
- Latency: rising `control` gives table[phase] on the first edge with control=1. The first advance occurs CLK_DIV edges after that.
- Step period is exactly CLK_DIV clocks. Each pattern is held CLK_DIV clocks, except the first pattern after enable, which is also held CLK_DIV clocks.
- CLK_DIV=1: phase advances every edge.
- Phase wraps: 3→0 (forward), 0→3 (reverse).
- Exactly one coil is high when control=1 (full-step). Never more than two coils are high in any mode.
- A `control` glitch of one cycle low gives 0000 for one cycle, and the prescaler restarts.

Optional Feature:
- Macro HALF_STEP_EN.
- Defined: phase is 3 bits with an 8-entry half-step table:
  - 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001
  - wrap mod 8;
  - same prescaler and REVERSE rules;
  - reset phase 0 (1000).
- Undefined: the 4-entry wave table above, with a 2-bit phase.

Decomposition:
- Package prototipo_uwu_pkg holds:
  - phase-table constants (full and half);
  - phase width localparam;
  - coil-vector typedef, 4-bit {A,B,C,D}.
- One natural sub-module: prototipo_uwu_prescaler. It is a counter with enable and clear, and emits a one-cycle tick at CLK_DIV-1.
- The sequencer and output register stay in the top module.

Test Plan:
- Reset: rst_n=0 for 2 cycles with control=1 → ABCD=0000, phase=0. Release with CLK_DIV=4 → 1000 held 4 clocks, then 0100.
- Full rotation: CLK_DIV=2, control=1 for 10 clocks → 1000,1000,0100,0100,0010,0010,0001,0001,1000,1000.
- Disable/resume: CLK_DIV=3. Drop control while showing 0010 → next edge 0000. Re-raise → 0010 held 3 clocks, then 0001.
- REVERSE=1, CLK_DIV=1, control=1 → 1000,0001,0010,0100,1000.
- Reset mid-run: while showing 0100, rst_n=0 for one edge → 0000. Next enabled edge → 1000.
- HALF_STEP_EN defined, CLK_DIV=1 → 1000,1100,0100,0110,0010,0011,0001,1001,1000; never more than two coils high.
